// File: rtl/int_x_event_writer_pkg.sv
// Shared definitions for the interrupt-X status event writer.
package int_x_event_writer_pkg;

  localparam int unsigned EVT_W  = 43;
  localparam int unsigned NUM_W  = 5;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned FLAG_W = 4;

  // Bit offsets of each field inside the event word
  localparam int unsigned OFS_OP_DONE  = 0;
  localparam int unsigned OFS_WR_ERROR = 1;
  localparam int unsigned OFS_RD_ERROR = 2;
  localparam int unsigned OFS_INVALID  = 3;
  localparam int unsigned OFS_NUM      = 4;
  localparam int unsigned OFS_EXT      = OFS_NUM + NUM_W;
  localparam int unsigned OFS_STR      = OFS_EXT + 1;
  localparam int unsigned OFS_ADDR     = OFS_STR + 1;

  // Descriptor identity occupies everything above the flag bits
  localparam int unsigned KEY_LO = OFS_NUM;
  localparam int unsigned KEY_W  = EVT_W - KEY_LO;

  localparam logic [EVT_W-1:0] FLAG_MASK = EVT_W'((64'd1 << FLAG_W) - 64'd1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              str;
    logic              ext;
    logic [NUM_W-1:0]  num;
    logic              invalid;
    logic              rd_error;
    logic              wr_error;
    logic              op_done;
  } evt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Extract the descriptor key used for coalescing
  function automatic logic [KEY_W-1:0] evt_key(input logic [EVT_W-1:0] word);
    return word[EVT_W-1:KEY_LO];
  endfunction

endpackage

// File: rtl/int_x_evt_pend_buf.sv
// Small register FIFO holding pending status events, with a tail rewrite port
// so a newer event can be merged into the most recent entry.
module int_x_evt_pend_buf
  import int_x_event_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [EVT_W-1:0]             push_data,
  input  logic                         pop,
  input  logic                         tail_wr,
  input  logic [EVT_W-1:0]             tail_data,
  output logic [EVT_W-1:0]             head,
  output logic [EVT_W-1:0]             tail,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (tail_wr && !empty) mem[tail_ptr] <= tail_data;
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/int_x_event_writer.sv
// Producer end of the interrupt-X status queue: captures engine events,
// coalesces events for the same descriptor and writes them one at a time.
module int_x_event_writer
  import int_x_event_writer_pkg::*;
#(
  parameter int unsigned PEND_DEPTH = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 evtStrb,
  input  logic                 evtOpDone,
  input  logic                 evtWrError,
  input  logic                 evtRdError,
  input  logic                 evtInvalid,
  input  logic [NUM_W-1:0]     evtDscrptrNum,
  input  logic                 evtExt,
  input  logic                 evtStr,
  input  logic [ADDR_W-1:0]    evtExtAddr,
  output logic                 evtRdy,
  input  logic                 fifoFullQueueX,
  output logic                 valid,
  output logic                 opDone,
  output logic                 wrError,
  output logic                 rdError,
  output logic                 inValidDscrptr,
  output logic [NUM_W-1:0]     intDscrptrNum,
  output logic                 extDscrptr,
  output logic                 strDscrptr,
  output logic [ADDR_W-1:0]    extDscrptrAddr,
  output logic                 stallArb,
  output logic                 evtOverflow
);

  localparam int unsigned CNT_W = $clog2(PEND_DEPTH + 1);
  localparam int unsigned GAP_W = 2;

  logic [EVT_W-1:0] in_word;
  logic [EVT_W-1:0] head_word;
  logic [EVT_W-1:0] tail_word;
  logic [EVT_W-1:0] merged_word;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;

  state_t           state;
  state_t           state_next;
  logic [GAP_W-1:0] gap_cnt;
  logic             go_issue;
  logic             pop;
  logic             gap_inc;

  logic             head_busy;
  logic             key_match;
  logic             can_merge;
  logic             coalesce;
  logic             push;
  logic             drop;

  evt_t             out_q;
  logic             valid_q;
  logic             rdy_q;
  logic             stall_q;
  logic             ovf_q;

  assign in_word = {evtExtAddr, evtStr, evtExt, evtDscrptrNum,
                    evtInvalid, evtRdError, evtWrError, evtOpDone};

  // Merge: identity is equal, so only the flag bits need combining
  assign merged_word = tail_word | (in_word & FLAG_MASK);

  // The head is committed to the output once the issue starts; never merge into it then
  assign head_busy = (state == ISSUE) || go_issue;
  assign key_match = !empty && (evt_key(tail_word) == evt_key(in_word));
  assign can_merge = key_match && !((count == CNT_W'(1)) && head_busy);
  assign coalesce  = evtStrb && can_merge;
  assign push      = evtStrb && !can_merge && !full;
  assign drop      = evtStrb && !can_merge && full;

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  int_x_evt_pend_buf #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_buf (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (in_word),
    .pop       (pop),
    .tail_wr   (coalesce),
    .tail_data (merged_word),
    .head      (head_word),
    .tail      (tail_word),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next-state logic; the queue watermark is only looked at in IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty && !fifoFullQueueX) state_next = ISSUE;
      ISSUE:   state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM control decode
  always_comb begin
    go_issue = 1'b0;
    pop      = 1'b0;
    gap_inc  = 1'b0;
    unique case (state)
      IDLE:    go_issue = (state_next == ISSUE);
      ISSUE:   pop      = 1'b1;
      GAP:     gap_inc  = 1'b1;
      default: ;
    endcase
  end

  // Gap cycle counter, cleared whenever the FSM is not in GAP
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      gap_cnt <= '0;
    else if (gap_inc) gap_cnt <= gap_cnt + GAP_W'(1);
    else              gap_cnt <= '0;
  end

  // Registered outputs: status fields latch the head as the issue starts
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      rdy_q   <= 1'b1;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= go_issue;
      if (go_issue) out_q <= evt_t'(head_word);
      rdy_q   <= (count_next < CNT_W'(PEND_DEPTH));
      stall_q <= fifoFullQueueX || (count >= CNT_W'(PEND_DEPTH - 1));
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign valid          = valid_q;
  assign opDone         = out_q.op_done;
  assign wrError        = out_q.wr_error;
  assign rdError        = out_q.rd_error;
  assign inValidDscrptr = out_q.invalid;
  assign intDscrptrNum  = out_q.num;
  assign extDscrptr     = out_q.ext;
  assign strDscrptr     = out_q.str;
  assign extDscrptrAddr = out_q.addr;
  assign evtRdy         = rdy_q;
  assign stallArb       = stall_q;
  assign evtOverflow    = ovf_q;

endmodule

// File: doc/int_x_event_writer.md
Name: int_x_event_writer

Overview:
- Producer end of the per-channel interrupt status queue.
- Collects completion and error events from the DMA read/write engines and the descriptor-fetch logic, then coalesces events that belong to the same descriptor.
- Buffers events in a small pending queue and writes one status event at a time into the interrupt-X queue FIFO through the valid/status-field interface.
- Honours the queue watermark and throttles upstream operation start when it cannot accept events.

Parameters:
- PEND_DEPTH, 2, pending-event buffer entries (power of 2, 2..8).
- GAP_CYCLES, 1, idle cycles forced after each queue write so the watermark flag settles (0..3).

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- evtStrb  input  1  one-cycle event strobe from the engines.
- evtOpDone  input  1  operation completed.
- evtWrError  input  1  write response error.
- evtRdError  input  1  read response error.
- evtInvalid  input  1  invalid descriptor.
- evtDscrptrNum  input  5  internal descriptor number.
- evtExt  input  1  external descriptor.
- evtStr  input  1  stream descriptor.
- evtExtAddr  input  32  external descriptor address.
- evtRdy  output  1  writer can accept an evtStrb this cycle.
- fifoFullQueueX  input  1  queue watermark reached.
- valid  output  1  queue write enable.
- opDone, wrError, rdError, inValidDscrptr  output  1 each  status fields.
- intDscrptrNum  output  5  status field.
- extDscrptr, strDscrptr  output  1 each  status fields.
- extDscrptrAddr  output  32  status field.
- stallArb  output  1  tells the arbiter not to start new operations.
- evtOverflow  output  1  sticky; an event was lost.

Behaviour:
- Reset: every output is 0 except evtRdy=1. Pending buffer is emptied, FSM is IDLE, and all counters are 0. Reset mid-operation discards buffered events with no partial write.
- Event word (43 bits): {evtExtAddr, evtStr, evtExt, evtDscrptrNum, evtInvalid, evtRdError, evtWrError, evtOpDone}.
- Capture: evtStrb & evtRdy pushes the word into the pending buffer at the next edge.
- Coalescing: if the newest unissued entry has an identical descriptor key {evtExt, evtStr, evtDscrptrNum, evtExtAddr}, the incoming flags are ORed into that entry instead of pushing. This applies even when the buffer is full and evtRdy=0.
- evtRdy = pending count < PEND_DEPTH.
- evtStrb while evtRdy=0 with no coalesce match: the event is dropped and evtOverflow is set. evtOverflow clears only on reset.
- FSM states:
  - IDLE: pending non-empty and !fifoFullQueueX → ISSUE.
  - ISSUE: valid=1 for exactly one cycle; output fields equal the head entry (registered, stable in the valid cycle); head is popped. Go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: count GAP_CYCLES cycles, then → IDLE.
- Outputs are registered, so latency from evtStrb (empty buffer, queue not full) to valid is 2 cycles.
- Status fields hold their last value outside valid. The receiver samples them only when valid=1.
- fifoFullQueueX is sampled only in IDLE. When it asserts, events wait indefinitely and none are lost while the buffer has room.
- Simultaneous push and pop: allowed. Count is unchanged and the pointers wrap modulo PEND_DEPTH.
- Coalescing is never applied to the head entry while it is being issued. If the only entry is the head in ISSUE, a matching strobe pushes a new entry.
- stallArb = fifoFullQueueX | (count >= PEND_DEPTH-1), registered.
- Empty buffer: valid is never asserted.
- Ext/str priority for descriptor identity is the same as in the queue: str overrides ext, which overrides the internal number. Fields are passed unmodified.

Decomposition:
- Shared package holds:
  - EVT_W = 43
  - field bit offsets within the event word
  - FSM state encodings IDLE/ISSUE/GAP
- One natural sub-module: int_x_evt_pend_buf (PEND_DEPTH×EVT_W register FIFO). It provides:
  - push/pop
  - a write-into-tail port for coalescing
  - count, full and empty outputs
- Compare/merge logic and the FSM stay in the top level.

Test Plan:
- Single event: evtStrb with OpDone=1, num=5, queue not full → valid=1 exactly 2 cycles later, intDscrptrNum=5, opDone=1, other flags 0; evtRdy stays 1.
- Coalesce: OpDone then WrError for num=7 on consecutive cycles, with fifoFullQueueX held high → after full drops, exactly one valid with opDone=1 and wrError=1.
- Backpressure: fifoFullQueueX=1 and 3 distinct events with PEND_DEPTH=2 → evtRdy=0 after the 2nd event, 3rd event is dropped, evtOverflow=1, stallArb=1. Release full → 2 valid pulses separated by ≥1 GAP cycle, in order.
- Wrap-around: 10 distinct back-to-back events spaced to fit, queue never full → 10 valid pulses in order with correct addresses (extDscrptr=1, addr=0x1000+4·i), pointers wrap cleanly.
- Simultaneous push/pop: strobe arrives in the same cycle the head is issued → count unchanged, no loss, no duplicate.
- Reset mid-operation: resetn low while 2 events are pending and in ISSUE → all outputs 0, evtRdy=1, no further valid after release.
